// File: rtl/maxpool_relu_dw1_pkg.sv
// maxpool_relu_dw1_pkg: shared defaults, pool size and signed saturation helper.
package maxpool_relu_dw1_pkg;
  localparam int I_BW_DEF = 20;
  localparam int O_BW_DEF = 16;
  localparam int IF_SIZE_DEF = 24;
  localparam int POOL_SIZE = 2;
  function automatic logic signed [63:0] clip_s(input logic signed [63:0] x, input int bw);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return x > hi ? hi : x < lo ? lo : x;
  endfunction
endpackage

// File: rtl/maxpool_relu_dw1_if.sv
// maxpool_relu_dw1_if: sample stream in, pooled stream out.
interface maxpool_relu_dw1_if
  import maxpool_relu_dw1_pkg::*;
#(
  parameter int I_BW = I_BW_DEF,
  parameter int O_BW = O_BW_DEF
);
  logic signed [I_BW-1:0] i_conv_result;
  logic i_valid_conv;
  logic signed [O_BW-1:0] o_pool_result;
  logic o_valid_pool;
  logic o_end_pool;
  modport master(output i_conv_result, i_valid_conv, input o_pool_result, o_valid_pool, o_end_pool);
  modport slave(input i_conv_result, i_valid_conv, output o_pool_result, o_valid_pool, o_end_pool);
endinterface

// File: rtl/maxpool_relu_dw1_pool_line_buffer.sv
// pool_line_buffer: one row of horizontal maxima, sync write, async read.
module pool_line_buffer #(
  parameter int DEPTH = 12,
  parameter int AW = 4,
  parameter int W = 16
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/maxpool_relu_dw1.sv
// maxpool_relu_dw1: 2x2 signed max pool of a raster map with saturation to O_BW.
// Define POOL_RELU_EN to zero negative samples before pooling.
module maxpool_relu_dw1
  import maxpool_relu_dw1_pkg::*;
#(
  parameter int I_BW = I_BW_DEF,
  parameter int O_BW = O_BW_DEF,
  parameter int IF_SIZE = IF_SIZE_DEF
) (
  input logic clk,
  input logic global_rst_n,
  input logic rst,
  input logic ce,
  maxpool_relu_dw1_if.slave pif
);
  localparam int LB_N = IF_SIZE / POOL_SIZE;
  localparam int AW = LB_N > 1 ? $clog2(LB_N) : 1;
  localparam int CW = AW + 1;
  if (IF_SIZE % POOL_SIZE != 0) begin : g_bad_size
    $error("IF_SIZE must be even");
  end
  logic [CW-1:0] r_col, r_row;
  logic signed [O_BW-1:0] r_hold, r_res, w_clip, w_s, w_hmax, w_pmax;
  logic [O_BW-1:0] w_lb;
  logic r_valid, r_end;
  logic w_acc, w_last_col, w_last_row, w_we;
  always_comb begin
    w_clip = O_BW'(clip_s(64'(pif.i_conv_result), O_BW));
`ifdef POOL_RELU_EN
    w_s = w_clip[O_BW-1] ? '0 : w_clip;
`else
    w_s = w_clip;
`endif
    w_hmax = w_s > r_hold ? w_s : r_hold;
    w_pmax = $signed(w_lb) > w_hmax ? $signed(w_lb) : w_hmax;
    w_acc = ce && pif.i_valid_conv;
    w_last_col = r_col == CW'(IF_SIZE - 1);
    w_last_row = r_row == CW'(IF_SIZE - 1);
    w_we = w_acc && !rst && r_col[0] && !r_row[0];
  end
  pool_line_buffer #(.DEPTH(LB_N), .AW(AW), .W(O_BW)) u_lb (
    .clk(clk),
    .i_we(w_we),
    .i_waddr(r_col[CW-1:1]),
    .i_wdata(w_hmax),
    .i_raddr(r_col[CW-1:1]),
    .o_rdata(w_lb)
  );
  always_ff @(posedge clk or negedge global_rst_n)
    if (!global_rst_n) begin
      r_col <= '0;
      r_row <= '0;
      r_hold <= '0;
      r_res <= '0;
      r_valid <= 1'b0;
      r_end <= 1'b0;
    end else if (rst) begin
      r_col <= '0;
      r_row <= '0;
      r_hold <= '0;
      r_res <= '0;
      r_valid <= 1'b0;
      r_end <= 1'b0;
    end else begin
      r_valid <= w_acc && r_col[0] && r_row[0];
      r_end <= w_acc && w_last_col && w_last_row;
      if (w_acc) begin
        r_col <= w_last_col ? '0 : r_col + 1'b1;
        if (w_last_col) r_row <= w_last_row ? '0 : r_row + 1'b1;
        if (!r_col[0]) r_hold <= w_s;
        if (r_col[0] && r_row[0]) r_res <= w_pmax;
      end
    end
  assign pif.o_pool_result = r_res;
  assign pif.o_valid_pool = r_valid;
  assign pif.o_end_pool = r_end;
endmodule

// File: tb/tb_maxpool_relu_dw1.sv
// tb_maxpool_relu_dw1: directed checks of pooling, clipping, gaps, clears and map chaining.
module tb_maxpool_relu_dw1;
  logic clk = 0, global_rst_n = 0, rst = 0, ce = 0;
  always #5 clk = ~clk;
  maxpool_relu_dw1_if #(.I_BW(20), .O_BW(16)) pif ();
  maxpool_relu_dw1 #(.I_BW(20), .O_BW(16), .IF_SIZE(24)) dut (
    .clk(clk), .global_rst_n(global_rst_n), .rst(rst), .ce(ce), .pif(pif)
  );
  int tests = 0, fails = 0;
  int q_val[$];
  bit q_end[$];
  logic ce_prev = 0;
  int ce_viol = 0;
  always @(posedge clk) ce_prev <= ce;
  always @(negedge clk)
    if (pif.o_valid_pool === 1'b1) begin
      q_val.push_back(int'(pif.o_pool_result));
      q_end.push_back(pif.o_end_pool);
      if (!ce_prev) ce_viol++;
    end
  task automatic cyc(input int v, input bit vld, input bit c);
    pif.i_conv_result = 20'(v);
    pif.i_valid_conv = vld;
    ce = c;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 1);
  endtask
  task automatic feed_ramp(input bit gaps);
    for (int r = 0; r < 24; r++)
      for (int c = 0; c < 24; c++) begin
        if (gaps)
          repeat ($urandom_range(0, 2)) begin
            if ($urandom_range(0, 1) == 1) cyc(999, 0, 1);
            else cyc(999, 1, 0);
          end
        cyc(r * 24 + c, 1, 1);
      end
  endtask
  function automatic int clip_px(input int r, input int c);
    if (r == 0 && c == 0) return 40000;
    if (r == 0 && c == 1) return -40000;
    if (r < 2 && (c == 2 || c == 3)) return -40000;
    if (r == 1 && c == 5) return 40000;
    return 0;
  endfunction
  task automatic test_reset;
    global_rst_n = 0;
    repeat (3) cyc(321, 1, 1);
    tests++;
    if (pif.o_pool_result !== 16'sd0) begin fails++; $display("FAIL reset_result got %0d want 0", pif.o_pool_result); end
    tests++;
    if (pif.o_valid_pool !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", pif.o_valid_pool); end
    tests++;
    if (pif.o_end_pool !== 1'b0) begin fails++; $display("FAIL reset_end got %b want 0", pif.o_end_pool); end
    global_rst_n = 1;
    idle(2);
  endtask
  task automatic test_ramp;
    q_val.delete(); q_end.delete();
    feed_ramp(0);
    idle(2);
    tests++;
    if (q_val.size() != 144) begin fails++; $display("FAIL ramp_count got %0d want 144", q_val.size()); end
    for (int k = 0; k < 144 && k < q_val.size(); k++) begin
      tests++;
      if (q_val[k] != (2 * (k / 12) + 1) * 24 + 2 * (k % 12) + 1 || q_end[k] != (k == 143)) begin
        fails++;
        $display("FAIL ramp_out[%0d] got %0d/end%0b want %0d/end%0b", k, q_val[k], q_end[k],
                 (2 * (k / 12) + 1) * 24 + 2 * (k % 12) + 1, k == 143);
      end
    end
    idle(5);
    tests++;
    if (pif.o_pool_result !== 16'sd575 || pif.o_valid_pool !== 1'b0) begin
      fails++; $display("FAIL ramp_hold got %0d/v%b want 575/v0", pif.o_pool_result, pif.o_valid_pool);
    end
  endtask
  task automatic test_async_reset;
    #2 global_rst_n = 0;
    #1;
    tests++;
    if (pif.o_pool_result !== 16'sd0 || pif.o_valid_pool !== 1'b0) begin
      fails++; $display("FAIL async_reset got %0d/v%b want 0/v0", pif.o_pool_result, pif.o_valid_pool);
    end
    @(posedge clk);
    #1 global_rst_n = 1;
    idle(1);
  endtask
  task automatic test_negative;
    int exp_v;
`ifdef POOL_RELU_EN
    exp_v = 0;
`else
    exp_v = -5;
`endif
    q_val.delete(); q_end.delete();
    repeat (576) cyc(-5, 1, 1);
    idle(2);
    tests++;
    if (q_val.size() != 144) begin fails++; $display("FAIL neg_count got %0d want 144", q_val.size()); end
    for (int k = 0; k < q_val.size(); k++) begin
      tests++;
      if (q_val[k] != exp_v) begin fails++; $display("FAIL neg_out[%0d] got %0d want %0d", k, q_val[k], exp_v); end
    end
  endtask
  task automatic test_clip;
    int exp_v, neg_v;
`ifdef POOL_RELU_EN
    neg_v = 0;
`else
    neg_v = -32768;
`endif
    q_val.delete(); q_end.delete();
    for (int r = 0; r < 24; r++)
      for (int c = 0; c < 24; c++) cyc(clip_px(r, c), 1, 1);
    idle(2);
    tests++;
    if (q_val.size() != 144) begin fails++; $display("FAIL clip_count got %0d want 144", q_val.size()); end
    for (int k = 0; k < q_val.size(); k++) begin
      exp_v = (k == 0 || k == 2) ? 32767 : (k == 1) ? neg_v : 0;
      tests++;
      if (q_val[k] != exp_v) begin fails++; $display("FAIL clip_out[%0d] got %0d want %0d", k, q_val[k], exp_v); end
    end
  endtask
  task automatic test_gaps;
    q_val.delete(); q_end.delete();
    ce_viol = 0;
    feed_ramp(1);
    idle(2);
    tests++;
    if (q_val.size() != 144) begin fails++; $display("FAIL gaps_count got %0d want 144", q_val.size()); end
    tests++;
    if (ce_viol != 0) begin fails++; $display("FAIL gaps_ce_low_valid got %0d want 0", ce_viol); end
    for (int k = 0; k < 144 && k < q_val.size(); k++) begin
      tests++;
      if (q_val[k] != (2 * (k / 12) + 1) * 24 + 2 * (k % 12) + 1) begin
        fails++; $display("FAIL gaps_out[%0d] got %0d want %0d", k, q_val[k], (2 * (k / 12) + 1) * 24 + 2 * (k % 12) + 1);
      end
    end
  endtask
  task automatic test_rst_abort;
    for (int i = 0; i < 300; i++) cyc((i / 24) * 24 + i % 24 + 1000, 1, 1);
    rst = 1;
    cyc(777, 1, 1);
    rst = 0;
    tests++;
    if (pif.o_pool_result !== 16'sd0 || pif.o_valid_pool !== 1'b0) begin
      fails++; $display("FAIL rst_clear got %0d/v%b want 0/v0", pif.o_pool_result, pif.o_valid_pool);
    end
    q_val.delete(); q_end.delete();
    feed_ramp(0);
    idle(2);
    tests++;
    if (q_val.size() != 144) begin fails++; $display("FAIL rst_count got %0d want 144", q_val.size()); end
    for (int k = 0; k < 144 && k < q_val.size(); k++) begin
      tests++;
      if (q_val[k] != (2 * (k / 12) + 1) * 24 + 2 * (k % 12) + 1) begin
        fails++; $display("FAIL rst_out[%0d] got %0d want %0d", k, q_val[k], (2 * (k / 12) + 1) * 24 + 2 * (k % 12) + 1);
      end
    end
  endtask
  task automatic test_back_to_back;
    q_val.delete(); q_end.delete();
    feed_ramp(0);
    feed_ramp(0);
    idle(2);
    tests++;
    if (q_val.size() != 288) begin fails++; $display("FAIL b2b_count got %0d want 288", q_val.size()); end
    for (int k = 0; k < 288 && k < q_val.size(); k++) begin
      tests++;
      if (q_val[k] != (2 * ((k % 144) / 12) + 1) * 24 + 2 * (k % 12) + 1 || q_end[k] != (k == 143 || k == 287)) begin
        fails++;
        $display("FAIL b2b_out[%0d] got %0d/end%0b want %0d/end%0b", k, q_val[k], q_end[k],
                 (2 * ((k % 144) / 12) + 1) * 24 + 2 * (k % 12) + 1, k == 143 || k == 287);
      end
    end
  endtask
  initial begin
    pif.i_conv_result = '0;
    pif.i_valid_conv = 0;
    test_reset();
    test_ramp();
    test_async_reset();
    test_negative();
    test_clip();
    test_gaps();
    test_rst_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
